activation_writeback: RTL

Post-MAC output stage of the neural accelerator. It accepts each finished neuron's signed accumulator value with its destination address, applies ReLU, a fixed-point rescale and unsigned saturation, and buffers the results in a small FIFO. It writes them into the neuron dual-port RAM through a ready/valid write port and reports per-layer completion to the control unit.

---
 rtl/activation_writeback.sv | 90 +++++++++
 1 files changed

// File: rtl/activation_writeback.sv
// activation_writeback: ReLU + rescale + saturate accumulator results, queue them in a FIFO
// and stream them into neuron RAM through a ready/valid write port.
module activation_writeback #(
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [ACC_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0]       in_addr,
    input  logic                        in_last,
    output logic                        wr_en,
    input  logic                        wr_ready,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [ADDR_WIDTH-1:0]       written,
    output logic                        done,
    output logic                        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] SAT = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
    state_t state;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [PW:0]           count;
    logic                  last_q, push, pop, load, hs;
    logic [ACC_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0] act;
    logic [EW-1:0]         head;

    assign in_ready = state == ACTIVE && count < (PW+1)'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;
    assign hs       = wr_en && wr_ready;
    // the output register refills when empty or when its current word is being taken
    assign load     = !wr_en || wr_ready;
    assign pop      = load && count != '0;
    assign head     = mem[rptr];
    assign busy     = state != IDLE;
    assign shifted  = ACC_WIDTH'(in_data >>> SHIFT);
    assign act      = (in_data[ACC_WIDTH-1] || in_data == '0) ? {DATA_WIDTH{1'b0}} :
                      (shifted > SAT) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];

    always_ff @(posedge clk)
        if (push) mem[wptr] <= {in_last, in_addr, act};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            wr_en <= count != '0;
            if (count != '0) {last_q, wr_addr, wr_data} <= head;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            written <= '0;
            done    <= 1'b0;
        end else begin
            done    <= state == FLUSH && hs && last_q;
            written <= (state == IDLE && start) ? '0 : hs ? written + ADDR_WIDTH'(1) : written;
            state   <= state == IDLE   ? (start ? ACTIVE : IDLE) :
                       state == ACTIVE ? ((push && in_last) ? FLUSH : ACTIVE) :
                                         ((hs && last_q) ? IDLE : FLUSH);
        end
endmodule
